hack_ram_arbiter: RTL and testbench

- Shares the single-port 16K-word Hack data RAM between two requesters.
  - Port A: CPU data port; priority requester.
  - Port B: loader/debug port, e.g. UART program/data loader or memory inspector.
- Uses a req/gnt handshake with starvation protection for port B.
- Routes the RAM's 1-cycle registered read data back to the requester that issued the read.
- Sits between the CPU/loader and the RAM instance; drives the RAM's we/addr/d_in and consumes its d_out.

---
 rtl/hack_ram_arbiter.sv | 100 ++++++++++
 tb/tb_hack_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_ram_arbiter.sv
// Two-port arbiter for the single-port Hack data RAM: CPU (A) has priority,
// loader/debug port (B) is force-granted after MAX_WAIT consecutive refusals.
module hack_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [15:0]           a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [15:0]           a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [15:0]           b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [15:0]           b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_d_in,
    input  logic [15:0]           ram_d_out
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rd_a_q, rd_a_d;
    logic              rd_b_q, rd_b_d;
    logic [DATA_W-1:0] a_hold_q, a_hold_d;
    logic [DATA_W-1:0] b_hold_q, b_hold_d;
    logic              force_b_c;

    // Grant: A has priority unless B has waited MAX_WAIT cycles.
    always_comb begin
        force_b_c = b_req && (wait_cnt_q == CNT_W'(MAX_WAIT));
        b_gnt     = b_req && (!a_req || force_b_c);
        a_gnt     = a_req && !b_gnt;
    end

    // RAM drive; idle cycles present A's address as a harmless read.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = a_addr;
        ram_d_in = a_wdata;
        if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_d_in = b_wdata;
        end else if (a_gnt) begin
            ram_we = a_we;
        end
        if (!rst_n) begin
            ram_we = 1'b0;
        end
    end

    // Starvation counter, read-return tags and read-data hold registers.
    always_comb begin
        wait_cnt_d = '0;
        if (b_req && !b_gnt) begin
            wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q
                                                          : wait_cnt_q + CNT_W'(1);
        end
        rd_a_d   = a_gnt && !a_we;
        rd_b_d   = b_gnt && !b_we;
        a_hold_d = rd_a_q ? ram_d_out : a_hold_q;
        b_hold_d = rd_b_q ? ram_d_out : b_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
        end
    end

    // Read data is live from the RAM on the valid cycle, held otherwise.
    always_comb begin
        a_rvalid = rd_a_q;
        b_rvalid = rd_b_q;
        a_rdata  = rd_a_q ? ram_d_out : a_hold_q;
        b_rdata  = rd_b_q ? ram_d_out : b_hold_q;
    end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Scoreboard bench for hack_ram_arbiter: directed scenarios plus random
// two-port traffic against a memory/arbitration reference model.
module tb_hack_ram_arbiter;

    localparam int AW = 14;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [15:0]   a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0]   a_rdata, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_d_in, ram_d_out;

    always #5 clk = ~clk;

    hack_ram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d_in(ram_d_in),
        .ram_d_out(ram_d_out)
    );

    // Environment: single-port RAM with registered read.
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d_in;
        ram_d_out <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [15:0] data; int cyc; } exp_t;
    exp_t a_q[$];
    exp_t b_q[$];
    logic [15:0] ref_mem [logic [AW-1:0]];
    int   refused = 0;
    logic ga, gb, dut_bg;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the model.
    task automatic tick();
        logic eb, ea;
        @(negedge clk);
        eb = b_req && (!a_req || refused >= MW);
        ea = a_req && !eb;
        chk("a_gnt", 32'(a_gnt), 32'(ea));
        chk("b_gnt", 32'(b_gnt), 32'(eb));
        dut_bg = b_gnt;
        if (eb) begin
            chk("ram_we_b", 32'(ram_we), 32'(b_we && rst_n));
            chk("ram_addr_b", 32'(ram_addr), 32'(b_addr));
            if (b_we) chk("ram_d_in_b", 32'(ram_d_in), 32'(b_wdata));
        end else if (ea) begin
            chk("ram_we_a", 32'(ram_we), 32'(a_we && rst_n));
            chk("ram_addr_a", 32'(ram_addr), 32'(a_addr));
            if (a_we) chk("ram_d_in_a", 32'(ram_d_in), 32'(a_wdata));
        end else begin
            chk("ram_we_idle", 32'(ram_we), 32'(0));
            chk("ram_addr_idle", 32'(ram_addr), 32'(a_addr));
        end
        if (rst_n) begin
            if (eb) begin
                if (b_we) ref_mem[b_addr] = b_wdata;
                else b_q.push_back('{ref_mem[b_addr], cyc + 1});
            end
            if (ea) begin
                if (a_we) ref_mem[a_addr] = a_wdata;
                else a_q.push_back('{ref_mem[a_addr], cyc + 1});
            end
            refused = (b_req && !eb) ? ((refused < MW) ? refused + 1 : refused) : 0;
        end else begin
            refused = 0;
        end
        ga = ea;
        gb = eb;
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(output logic r, output logic w, output logic [AW-1:0] ad,
                           output logic [15:0] d);
        r  = ($urandom_range(0, 9) < 7);
        w  = ($urandom_range(0, 2) == 0);
        ad = rnd_addr();
        d  = 16'($urandom);
    endtask

    // Monitor: pops the scoreboard whenever a port presents read data.
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_a_rvalid", 32'(a_rvalid), 32'(0));
                chk("rst_b_rvalid", 32'(b_rvalid), 32'(0));
                chk("rst_a_rdata", 32'(a_rdata), 32'(0));
                chk("rst_b_rdata", 32'(b_rdata), 32'(0));
                last_a = '0;
                last_b = '0;
            end else begin
                if (a_rvalid) begin
                    n_cmp++;
                    if (a_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL a_rvalid_spurious: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        n_cmp--;
                        e = a_q.pop_front();
                        chk("a_rdata", 32'(a_rdata), 32'(e.data));
                        chk("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                        last_a = e.data;
                    end
                end else begin
                    chk("a_rdata_hold", 32'(a_rdata), 32'(last_a));
                    if (a_q.size() > 0 && a_q[0].cyc <= cyc) begin
                        e = a_q.pop_front();
                        chk("a_rvalid_missing", 32'(a_rvalid), 32'(1));
                    end
                end
                if (b_rvalid) begin
                    n_cmp++;
                    if (b_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL b_rvalid_spurious: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        n_cmp--;
                        e = b_q.pop_front();
                        chk("b_rdata", 32'(b_rdata), 32'(e.data));
                        chk("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                        last_b = e.data;
                    end
                end else begin
                    chk("b_rdata_hold", 32'(b_rdata), 32'(last_b));
                    if (b_q.size() > 0 && b_q[0].cyc <= cyc) begin
                        e = b_q.pop_front();
                        chk("b_rvalid_missing", 32'(b_rvalid), 32'(1));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Preload every address the traffic uses.
        a_req = 1; a_we = 1;
        for (int i = 0; i < 17; i++) begin
            a_addr  = (i == 16) ? 14'h3FFF : 14'(i);
            a_wdata = (i == 1) ? 16'h1111 : (i == 2) ? 16'h2222 : 16'($urandom);
            tick();
        end
        a_req = 0; tick();

        // A write then read.
        a_req = 1; a_we = 1; a_addr = 14'h0010; a_wdata = 16'h1234; tick();
        a_we = 0; tick();
        a_req = 0; tick(); tick();
        chk("t1_a_hold", 32'(a_rdata), 32'h1234);

        // B alone write then read at the top address.
        b_req = 1; b_we = 1; b_addr = 14'h3FFF; b_wdata = 16'hBEEF; tick();
        b_we = 0; tick();
        b_req = 0; tick();
        chk("t2_b_hold", 32'(b_rdata), 32'hBEEF);

        // Continuous contention: A,A,A,A,B repeating.
        a_req = 1; a_we = 0; a_addr = rnd_addr();
        b_req = 1; b_we = 0; b_addr = rnd_addr();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_pattern", 32'(dut_bg), 32'((i % 5) == 4));
            if (ga) a_addr = rnd_addr();
            if (gb) b_addr = rnd_addr();
        end
        a_req = 0; b_req = 0; tick(); tick();

        // Interleaved reads on consecutive cycles.
        a_req = 1; a_we = 0; a_addr = 14'h0001; tick();
        a_req = 0; b_req = 1; b_we = 0; b_addr = 14'h0002; tick();
        b_req = 0; tick(); tick();
        chk("t4_a_hold", 32'(a_rdata), 32'h1111);
        chk("t4_b_hold", 32'(b_rdata), 32'h2222);

        // Cross-port write then read.
        a_req = 1; a_we = 1; a_addr = 14'h0005; a_wdata = 16'h00AA; tick();
        a_req = 0; b_req = 1; b_we = 0; b_addr = 14'h0005; tick();
        b_req = 0; tick(); tick();
        chk("t5_b_hold", 32'(b_rdata), 32'h00AA);

        // Reset right after a B read grant drops the read.
        b_req = 1; b_we = 0; b_addr = 14'h0002; tick();
        b_req = 0; rst_n = 1'b0;
        a_q.delete(); b_q.delete();
        a_req = 1; a_we = 1; a_addr = 14'h0005; a_wdata = 16'hFFFF;
        tick(); tick();
        rst_n = 1'b1; a_we = 0; b_req = 1; b_we = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_pattern", 32'(dut_bg), 32'((i % 5) == 4));
            if (ga) a_addr = rnd_addr();
            if (gb) b_addr = rnd_addr();
        end
        a_req = 0; b_req = 0; tick(); tick();
        chk("t6_no_write", 32'(b_rdata), 32'(last_b));

        // Random traffic with occasional B withdrawal.
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ga || !a_req) new_req(a_req, a_we, a_addr, a_wdata);
            if (gb || !b_req) new_req(b_req, b_we, b_addr, b_wdata);
            else if ($urandom_range(0, 15) == 0) b_req = 0;
        end
        a_req = 0; b_req = 0;
        tick(); tick(); tick();
        chk("a_q_drained", 32'(a_q.size()), 32'(0));
        chk("b_q_drained", 32'(b_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
